// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen
// Walks one convolution layer output pixel by output pixel. Within a pixel the
// order is output-channel tile, kernel row, kernel column, input-channel word.
// One IFM word address and one filter word address are emitted per beat.
// Addresses come from add-only accumulators. The only multiplies are in the
// config latch, which runs once per layer.
module conv_window_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 8,
  parameter int MUL_PER_PE = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_flt_base,
  input  logic [DIM_W-1:0]  cfg_ifm_w,
  input  logic [DIM_W-1:0]  cfg_ifm_c,
  input  logic [DIM_W-1:0]  cfg_ofm_w,
  input  logic [DIM_W-1:0]  cfg_oc_tiles,
  input  logic [3:0]        cfg_kernel_w,
  input  logic [1:0]        cfg_stride,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] flt_addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              window_last,
  output logic              layer_last,
  output logic              busy,
  output logic              done
);

  localparam int                MPP_SH    = $clog2(MUL_PER_PE);
  localparam logic [ADDR_W-1:0] ICT_STEP  = ADDR_W'(MUL_PER_PE);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_r;

  // Latched layer geometry (loop maxima and accumulator steps)
  logic [DIM_W-1:0]  ofm_max_r, oc_max_r, ict_max_r;
  logic [3:0]        k_max_r;
  logic [ADDR_W-1:0] flt_base_r, kx_step_r, ky_step_r, pix_step_r, row_step_r;

  // Loop position of the beat currently presented
  logic [DIM_W-1:0]  oy_r, ox_r, oct_r, ict_r;
  logic [3:0]        ky_r, kx_r;

  // Accumulators: start of output row, output pixel, kernel row, kernel column
  logic [ADDR_W-1:0] row_base_r, pix_base_r, ky_base_r, kx_base_r;

  // Registered outputs
  logic [ADDR_W-1:0] ifm_addr_r, flt_addr_r;
  logic              window_last_r, layer_last_r, done_r;

  // Derived config values
  logic [DIM_W-1:0]  ic_t_s;
  logic [ADDR_W-1:0] kx_step_s, ky_step_s, pix_step_s, row_step_s;
  logic              first_win_s, first_layer_s;

  // Next-beat values
  logic [DIM_W-1:0]  oy_nxt_s, ox_nxt_s, oct_nxt_s, ict_nxt_s;
  logic [3:0]        ky_nxt_s, kx_nxt_s;
  logic [ADDR_W-1:0] row_base_nxt_s, pix_base_nxt_s, ky_base_nxt_s, kx_base_nxt_s;
  logic [ADDR_W-1:0] ifm_nxt_s, flt_nxt_s;
  logic [ADDR_W-1:0] row_sum_s, pix_sum_s, ky_sum_s, kx_sum_s;
  logic              win_nxt_s, layer_nxt_s;

  // Derive steps and first-beat flags from the live config for the latch cycle
  always_comb begin
    ic_t_s        = cfg_ifm_c >> MPP_SH;
    kx_step_s     = ADDR_W'(cfg_ifm_c);
    ky_step_s     = ADDR_W'(cfg_ifm_w) * kx_step_s;
    pix_step_s    = kx_step_s * ADDR_W'(cfg_stride);
    row_step_s    = ky_step_s * ADDR_W'(cfg_stride);
    first_win_s   = (ic_t_s == DIM_ONE) && (cfg_kernel_w == 4'd1) && (cfg_oc_tiles == DIM_ONE);
    first_layer_s = first_win_s && (cfg_ofm_w == DIM_ONE);
  end

  // Advance the loop nest by one beat; the innermost non-wrapping counter wins
  always_comb begin
    oy_nxt_s       = oy_r;
    ox_nxt_s       = ox_r;
    oct_nxt_s      = oct_r;
    ky_nxt_s       = ky_r;
    kx_nxt_s       = kx_r;
    ict_nxt_s      = ict_r;
    row_base_nxt_s = row_base_r;
    pix_base_nxt_s = pix_base_r;
    ky_base_nxt_s  = ky_base_r;
    kx_base_nxt_s  = kx_base_r;
    ifm_nxt_s      = ifm_addr_r;
    flt_nxt_s      = flt_addr_r + WORD_STEP;
    row_sum_s      = row_base_r + row_step_r;
    pix_sum_s      = pix_base_r + pix_step_r;
    ky_sum_s       = ky_base_r + ky_step_r;
    kx_sum_s       = kx_base_r + kx_step_r;
    if (ict_r != ict_max_r) begin
      ict_nxt_s = ict_r + DIM_ONE;
      ifm_nxt_s = ifm_addr_r + ICT_STEP;
    end else if (kx_r != k_max_r) begin
      ict_nxt_s     = DIM_ZERO;
      kx_nxt_s      = kx_r + 4'd1;
      kx_base_nxt_s = kx_sum_s;
      ifm_nxt_s     = kx_sum_s;
    end else if (ky_r != k_max_r) begin
      ict_nxt_s     = DIM_ZERO;
      kx_nxt_s      = 4'd0;
      ky_nxt_s      = ky_r + 4'd1;
      ky_base_nxt_s = ky_sum_s;
      kx_base_nxt_s = ky_sum_s;
      ifm_nxt_s     = ky_sum_s;
    end else if (oct_r != oc_max_r) begin
      // Next output-channel tile replays the same IFM window; widx keeps counting
      ict_nxt_s     = DIM_ZERO;
      kx_nxt_s      = 4'd0;
      ky_nxt_s      = 4'd0;
      oct_nxt_s     = oct_r + DIM_ONE;
      ky_base_nxt_s = pix_base_r;
      kx_base_nxt_s = pix_base_r;
      ifm_nxt_s     = pix_base_r;
    end else if (ox_r != ofm_max_r) begin
      ict_nxt_s      = DIM_ZERO;
      kx_nxt_s       = 4'd0;
      ky_nxt_s       = 4'd0;
      oct_nxt_s      = DIM_ZERO;
      ox_nxt_s       = ox_r + DIM_ONE;
      pix_base_nxt_s = pix_sum_s;
      ky_base_nxt_s  = pix_sum_s;
      kx_base_nxt_s  = pix_sum_s;
      ifm_nxt_s      = pix_sum_s;
      flt_nxt_s      = flt_base_r;
    end else if (oy_r != ofm_max_r) begin
      ict_nxt_s      = DIM_ZERO;
      kx_nxt_s       = 4'd0;
      ky_nxt_s       = 4'd0;
      oct_nxt_s      = DIM_ZERO;
      ox_nxt_s       = DIM_ZERO;
      oy_nxt_s       = oy_r + DIM_ONE;
      row_base_nxt_s = row_sum_s;
      pix_base_nxt_s = row_sum_s;
      ky_base_nxt_s  = row_sum_s;
      kx_base_nxt_s  = row_sum_s;
      ifm_nxt_s      = row_sum_s;
      flt_nxt_s      = flt_base_r;
    end else begin
      // Final beat of the layer: the FSM leaves RUN, position is not used again
      flt_nxt_s = flt_base_r;
    end
    win_nxt_s   = (ict_nxt_s == ict_max_r) && (kx_nxt_s == k_max_r) &&
                  (ky_nxt_s == k_max_r) && (oct_nxt_s == oc_max_r);
    layer_nxt_s = win_nxt_s && (ox_nxt_s == ofm_max_r) && (oy_nxt_s == ofm_max_r);
  end

  // Control FSM with config latch, loop counters, accumulators and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ofm_max_r     <= DIM_ZERO;
      oc_max_r      <= DIM_ZERO;
      ict_max_r     <= DIM_ZERO;
      k_max_r       <= 4'd0;
      flt_base_r    <= ADDR_ZERO;
      kx_step_r     <= ADDR_ZERO;
      ky_step_r     <= ADDR_ZERO;
      pix_step_r    <= ADDR_ZERO;
      row_step_r    <= ADDR_ZERO;
      oy_r          <= DIM_ZERO;
      ox_r          <= DIM_ZERO;
      oct_r         <= DIM_ZERO;
      ict_r         <= DIM_ZERO;
      ky_r          <= 4'd0;
      kx_r          <= 4'd0;
      row_base_r    <= ADDR_ZERO;
      pix_base_r    <= ADDR_ZERO;
      ky_base_r     <= ADDR_ZERO;
      kx_base_r     <= ADDR_ZERO;
      ifm_addr_r    <= ADDR_ZERO;
      flt_addr_r    <= ADDR_ZERO;
      window_last_r <= 1'b0;
      layer_last_r  <= 1'b0;
      done_r        <= 1'b0;
    end else if (abort) begin
      // Abort beats start and any transfer in the same cycle
      state_r       <= ST_IDLE;
      window_last_r <= 1'b0;
      layer_last_r  <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A start seen while done is still high is ignored
          if (start && !done_r) begin
            state_r       <= ST_RUN;
            ofm_max_r     <= cfg_ofm_w - DIM_ONE;
            oc_max_r      <= cfg_oc_tiles - DIM_ONE;
            ict_max_r     <= ic_t_s - DIM_ONE;
            k_max_r       <= cfg_kernel_w - 4'd1;
            flt_base_r    <= cfg_flt_base;
            kx_step_r     <= kx_step_s;
            ky_step_r     <= ky_step_s;
            pix_step_r    <= pix_step_s;
            row_step_r    <= row_step_s;
            oy_r          <= DIM_ZERO;
            ox_r          <= DIM_ZERO;
            oct_r         <= DIM_ZERO;
            ict_r         <= DIM_ZERO;
            ky_r          <= 4'd0;
            kx_r          <= 4'd0;
            row_base_r    <= cfg_ifm_base;
            pix_base_r    <= cfg_ifm_base;
            ky_base_r     <= cfg_ifm_base;
            kx_base_r     <= cfg_ifm_base;
            ifm_addr_r    <= cfg_ifm_base;
            flt_addr_r    <= cfg_flt_base;
            window_last_r <= first_win_s;
            layer_last_r  <= first_layer_s;
          end else begin
            state_r <= ST_IDLE;
          end
          done_r <= 1'b0;
        end
        ST_RUN: begin
          // addr_valid is high throughout RUN, so ready alone marks a transfer
          if (addr_ready) begin
            if (layer_last_r) begin
              state_r       <= ST_IDLE;
              window_last_r <= 1'b0;
              layer_last_r  <= 1'b0;
              done_r        <= 1'b1;
            end else begin
              oy_r          <= oy_nxt_s;
              ox_r          <= ox_nxt_s;
              oct_r         <= oct_nxt_s;
              ky_r          <= ky_nxt_s;
              kx_r          <= kx_nxt_s;
              ict_r         <= ict_nxt_s;
              row_base_r    <= row_base_nxt_s;
              pix_base_r    <= pix_base_nxt_s;
              ky_base_r     <= ky_base_nxt_s;
              kx_base_r     <= kx_base_nxt_s;
              ifm_addr_r    <= ifm_nxt_s;
              flt_addr_r    <= flt_nxt_s;
              window_last_r <= win_nxt_s;
              layer_last_r  <= layer_nxt_s;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ifm_addr    = ifm_addr_r;
  assign flt_addr    = flt_addr_r;
  assign addr_valid  = (state_r == ST_RUN);
  assign busy        = (state_r == ST_RUN);
  assign window_last = window_last_r;
  assign layer_last  = layer_last_r;
  assign done        = done_r;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Testbench for conv_window_addr_gen. The expected beat list of each layer is
// built with nested loops and the closed-form address formulas. A single
// compare process checks every valid cycle against that list. Hand-computed
// pins then tie selected beats to literal values.
module tb_conv_window_addr_gen;

  localparam int DEPTH = 4096;
  localparam int LIMIT = 5000;
  localparam int MPP   = 4;
  localparam int WB    = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, addr_ready;
  logic [31:0] cfg_ifm_base, cfg_flt_base;
  logic [7:0]  cfg_ifm_w, cfg_ifm_c, cfg_ofm_w, cfg_oc_tiles;
  logic [3:0]  cfg_kernel_w;
  logic [1:0]  cfg_stride;
  logic [31:0] ifm_addr, flt_addr;
  logic        addr_valid, window_last, layer_last, busy, done;

  int          checks = 0;
  int          errors = 0;
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  int          lay_base = 0;
  bit          exp_done = 1'b0;
  bit          timeout_flag = 1'b0;
  bit          rand_ready = 1'b0;
  bit          ready_level = 1'b1;

  logic [31:0] exp_ifm [DEPTH];
  logic [31:0] exp_flt [DEPTH];
  bit          exp_wl  [DEPTH];
  bit          exp_ll  [DEPTH];
  bit          pin_i_en [DEPTH];
  logic [31:0] pin_i_val[DEPTH];
  bit          pin_f_en [DEPTH];
  logic [31:0] pin_f_val[DEPTH];
  bit          pin_w_en [DEPTH];
  bit          pin_l_en [DEPTH];

  conv_window_addr_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_ifm_base (cfg_ifm_base),
    .cfg_flt_base (cfg_flt_base),
    .cfg_ifm_w    (cfg_ifm_w),
    .cfg_ifm_c    (cfg_ifm_c),
    .cfg_ofm_w    (cfg_ofm_w),
    .cfg_oc_tiles (cfg_oc_tiles),
    .cfg_kernel_w (cfg_kernel_w),
    .cfg_stride   (cfg_stride),
    .ifm_addr     (ifm_addr),
    .flt_addr     (flt_addr),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .window_last  (window_last),
    .layer_last   (layer_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Ready driver: changes just after each rising edge
  initial begin
    addr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) addr_ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      else            addr_ready = ready_level;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: samples on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("no_timeout", {31'd0, timeout_flag}, 32'd0);
      if (!rst_n) begin
        chk("rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wlast", {31'd0, window_last}, 32'd0);
        chk("rst_llast", {31'd0, layer_last}, 32'd0);
        chk("rst_ifm", ifm_addr, 32'd0);
        chk("rst_flt", flt_addr, 32'd0);
        rd_ptr   = wr_ptr;
        exp_done = 1'b0;
      end else begin
        chk("done", {31'd0, done}, {31'd0, exp_done});
        exp_done = 1'b0;
        chk("busy_eq_valid", {31'd0, busy}, {31'd0, addr_valid});
        if (addr_valid) begin
          chk("beat_expected", {31'd0, (rd_ptr != wr_ptr)}, 32'd1);
          if (rd_ptr != wr_ptr) begin
            chk("ifm_addr", ifm_addr, exp_ifm[rd_ptr]);
            chk("flt_addr", flt_addr, exp_flt[rd_ptr]);
            chk("window_last", {31'd0, window_last}, {31'd0, exp_wl[rd_ptr]});
            chk("layer_last", {31'd0, layer_last}, {31'd0, exp_ll[rd_ptr]});
            if (pin_i_en[rd_ptr]) chk("pin_ifm", ifm_addr, pin_i_val[rd_ptr]);
            if (pin_f_en[rd_ptr]) chk("pin_flt", flt_addr, pin_f_val[rd_ptr]);
            if (pin_w_en[rd_ptr]) chk("pin_wlast", {31'd0, window_last}, 32'd1);
            if (pin_l_en[rd_ptr]) chk("pin_llast", {31'd0, layer_last}, 32'd1);
            if (abort) begin
              rd_ptr = wr_ptr;
            end else if (addr_ready) begin
              exp_done = exp_ll[rd_ptr];
              rd_ptr++;
            end
          end
        end
      end
    end
  end

  // Program the config inputs and append the expected beats of that layer
  task automatic setup_layer(input logic [31:0] ib, input logic [31:0] fb, input int iw,
                             input int ic, input int ow, input int oct_n, input int k,
                             input int s);
    int ict_n;
    cfg_ifm_base = ib;
    cfg_flt_base = fb;
    cfg_ifm_w    = 8'(iw);
    cfg_ifm_c    = 8'(ic);
    cfg_ofm_w    = 8'(ow);
    cfg_oc_tiles = 8'(oct_n);
    cfg_kernel_w = 4'(k);
    cfg_stride   = 2'(s);
    ict_n        = ic / MPP;
    lay_base     = wr_ptr;
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int oc = 0; oc < oct_n; oc++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              for (int ict = 0; ict < ict_n; ict++) begin
                exp_ifm[wr_ptr] = ib + 32'(((oy * s + ky) * iw + (ox * s + kx)) * ic + ict * MPP);
                exp_flt[wr_ptr] = fb + 32'((((oc * k + ky) * k + kx) * ict_n + ict) * WB);
                exp_wl[wr_ptr]  = (oc == oct_n - 1) && (ky == k - 1) && (kx == k - 1) &&
                                  (ict == ict_n - 1);
                exp_ll[wr_ptr]  = exp_wl[wr_ptr] && (oy == ow - 1) && (ox == ow - 1);
                wr_ptr++;
              end
  endtask

  task automatic pin_i(input int beat, input logic [31:0] v);
    pin_i_en[lay_base + beat - 1]  = 1'b1;
    pin_i_val[lay_base + beat - 1] = v;
  endtask

  task automatic pin_f(input int beat, input logic [31:0] v);
    pin_f_en[lay_base + beat - 1]  = 1'b1;
    pin_f_val[lay_base + beat - 1] = v;
  endtask

  task automatic pin_w(input int beat);
    pin_w_en[lay_base + beat - 1] = 1'b1;
  endtask

  task automatic pin_l(input int beat);
    pin_l_en[lay_base + beat - 1] = 1'b1;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  // Bounded wait until the DUT is idle and every expected beat was consumed
  task automatic wait_idle();
    int n = 0;
    while ((busy || rd_ptr != wr_ptr) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      timeout_flag = 1'b1;
      repeat (2) @(negedge clk);
      finish_run();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    setup_layer(32'h0, 32'h0, 5, 8, 1, 1, 1, 1);
    wr_ptr = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic geometry, ready held high
    setup_layer(32'h0, 32'h0, 5, 8, 3, 1, 3, 1);
    pin_i(1, 32'd0);  pin_i(2, 32'd4);  pin_i(3, 32'd8);  pin_i(4, 32'd12);
    pin_i(5, 32'd16); pin_i(6, 32'd20); pin_i(7, 32'd40); pin_i(19, 32'd8);
    pin_f(18, 32'd68); pin_f(19, 32'd0);
    pin_w(18); pin_w(36); pin_l(162); pin_i(162, 32'd196);
    start_pulse();
    wait_idle();

    // Same layer under random back-pressure
    rand_ready = 1'b1;
    setup_layer(32'h0, 32'h0, 5, 8, 3, 1, 3, 1);
    pin_i(7, 32'd40); pin_i(19, 32'd8); pin_w(18); pin_l(162);
    start_pulse();
    wait_idle();
    rand_ready = 1'b0;

    // Stride 2 and filter replay per pixel
    setup_layer(32'h0, 32'h0, 7, 4, 3, 1, 3, 2);
    pin_i(10, 32'd8); pin_i(28, 32'd56); pin_i(81, 32'd192);
    pin_f(9, 32'd32); pin_f(10, 32'd0); pin_f(81, 32'd32); pin_l(81);
    start_pulse();
    wait_idle();

    // Two output-channel tiles on the basic geometry
    setup_layer(32'h0, 32'h0, 5, 8, 3, 2, 3, 1);
    pin_f(36, 32'd140); pin_f(37, 32'd0); pin_i(19, 32'd0); pin_i(37, 32'd8);
    pin_w(36); pin_w(72);
    start_pulse();
    wait_idle();

    // Abort at beat 50, then restart from the base
    setup_layer(32'h100, 32'h800, 5, 8, 3, 1, 3, 1);
    start_pulse();
    repeat (49) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    setup_layer(32'h100, 32'h800, 5, 8, 3, 1, 3, 1);
    pin_i(1, 32'h100); pin_f(1, 32'h800); pin_i(162, 32'h1C4); pin_l(162);
    start_pulse();
    wait_idle();

    // Asynchronous reset mid-layer, then restart
    setup_layer(32'h300, 32'h600, 7, 4, 3, 1, 3, 2);
    start_pulse();
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    setup_layer(32'h300, 32'h600, 7, 4, 3, 1, 3, 2);
    pin_i(1, 32'h300); pin_f(1, 32'h600); pin_l(81);
    start_pulse();
    wait_idle();

    // Start held through the whole layer and its done cycle; config disturbed mid-run
    begin
      int n = 0;
      setup_layer(32'h40, 32'h400, 7, 4, 3, 1, 3, 2);
      pin_i(81, 32'h100);
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2;
      cfg_ifm_base = 32'hDEAD0;
      cfg_ifm_w    = 8'd9;
      cfg_ifm_c    = 8'd12;
      cfg_kernel_w = 4'd2;
      cfg_stride   = 2'd1;
      cfg_oc_tiles = 8'd3;
      while (!done && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      if (n >= LIMIT) begin
        timeout_flag = 1'b1;
        repeat (2) @(negedge clk);
        finish_run();
      end
      @(posedge clk);
      #2 start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
    end

    // Fresh config after the held start: K=1, window_last on every beat
    setup_layer(32'h10, 32'h20, 4, 4, 4, 1, 1, 1);
    pin_w(1); pin_i(2, 32'h14); pin_i(16, 32'h4C); pin_f(16, 32'h20); pin_l(16);
    start_pulse();
    wait_idle();

    finish_run();
  end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Parametrised IFM/filter address generator for the convolution datapath. It sits between the layer controller and the IFM and weight SRAM read ports. For each output pixel it walks one output-channel tile, kernel row, kernel column and input-channel word in a fixed nested order, emitting one IFM word address and one filter word address per beat. Compared with the previous fixed-geometry generator it adds:

- run-time stride
- variable channel tiling
- valid/ready back-pressure
- per-window and end-of-layer markers

## Interface

Parameters:
- ADDR_W, 32: address width, bytes.
- DIM_W, 8: width of all geometry fields.
- MUL_PER_PE, 4: channels packed per SRAM word; byte per channel; power of 2.
- WORD_BYTES, 4: address step between consecutive words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  latch config and begin a layer; honoured only in IDLE.
- abort  in  1  synchronous; return to IDLE next cycle, no done pulse.
- cfg_ifm_base  in  ADDR_W  IFM byte base address.
- cfg_flt_base  in  ADDR_W  filter byte base address.
- cfg_ifm_w  in  DIM_W  IFM width (pixels); IFM is square, HWC layout.
- cfg_ifm_c  in  DIM_W  IFM channels; multiple of MUL_PER_PE, at least MUL_PER_PE.
- cfg_ofm_w  in  DIM_W  OFM width; square.
- cfg_oc_tiles  in  DIM_W  output-channel tiles per pixel; at least 1.
- cfg_kernel_w  in  4  kernel width K, 1..7.
- cfg_stride  in  2  stride, 1..3.
- ifm_addr  out  ADDR_W  IFM word address.
- flt_addr  out  ADDR_W  filter word address.
- addr_valid  out  1  addresses valid.
- addr_ready  in  1  consumer accepts the beat.
- window_last  out  1  final beat of the current output pixel.
- layer_last  out  1  final beat of the layer.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation

- States: IDLE, RUN.
  - IDLE + start: latch all cfg_* into internal registers, clear all counters, go to RUN.
  - RUN + final accepted beat: go to IDLE and pulse done.
  - abort in any state: go to IDLE, addr_valid=0, no done pulse.
- Derived value: IC_T = cfg_ifm_c / MUL_PER_PE, computed by shift.
- Loop nest, outermost first. Each counter runs to its limit minus 1 and wraps to 0:
  - oy, ox: 0..OFM_W-1
  - oct: 0..oc_tiles-1
  - ky, kx: 0..K-1
  - ict: 0..IC_T-1
- Addresses, full ADDR_W modulo arithmetic:
  - iy = oy*stride + ky; ix = ox*stride + kx.
  - ifm_addr = ifm_base + (iy*IFM_W + ix)*IFM_C + ict*MUL_PER_PE.
  - flt_addr = flt_base + widx*WORD_BYTES, where widx = ((oct*K + ky)*K + kx)*IC_T + ict.
  - widx restarts at 0 for every output pixel, so the same weights are replayed per pixel.
- Addresses are produced by incremental row/pixel/window accumulators: add-only, no multipliers on the per-beat path. Multiplies are allowed only in the one-cycle config latch.
- Beats per pixel = oc_tiles*K*K*IC_T. Total beats = OFM_W² × that.
- Flags:
  - window_last = (oct, ky, kx, ict) all at their maxima.
  - layer_last = window_last && oy, ox at their maxima.
- No bounds or padding check: the config must satisfy (OFM_W-1)*stride + K <= IFM_W.
- cfg_* changes during RUN have no effect.

## Timing

- Reset values: addr_valid=0, busy=0, done=0, window_last=0, layer_last=0, ifm_addr=0, flt_addr=0; state IDLE.
- start sampled at edge N → busy=1 and addr_valid=1 with the first beat from edge N+1.
- Handshake:
  - A beat transfers when addr_valid && addr_ready.
  - While addr_ready=0, ifm_addr, flt_addr, window_last and layer_last hold stable.
  - Counters advance only on a transfer.
- Throughput: one beat per cycle with addr_ready held high; no bubbles at window, row or oc-tile wrap.
- Final transfer at edge M → at edge M+1: addr_valid=0, busy=0, done=1 for one cycle.
- start asserted in the same cycle as done or in RUN is ignored. A new start is accepted from the first IDLE cycle.
- abort has priority over start and over a simultaneous transfer.
- rst_n assertion mid-layer clears everything asynchronously. No done pulse.

## Test plan

- Basic geometry: K=3, IFM_W=5, IFM_C=8, OFM_W=3, oc_tiles=1, stride=1, bases 0, ready held high.
  - First beats ifm_addr = 0,4,8,12,16,20,40.
  - 18 beats per pixel; window_last on beats 18, 36, …; 162 beats total.
  - Second pixel starts at 8; done exactly 1 cycle after beat 162.
- Stride and filter replay: stride=2, IFM_W=7, IFM_C=4, OFM_W=3, K=3.
  - Pixel (0,1) starts at 8; pixel (1,0) starts at 56.
  - Final ifm_addr = 192.
  - flt_addr cycles 0..32 and returns to 0 at every pixel.
- Output-channel tiles: oc_tiles=2 with the basic geometry.
  - 36 beats per pixel; the IFM sequence repeats twice per pixel.
  - flt_addr runs 0..140 (widx 0..35).
- Back-pressure: random addr_ready at 50% duty.
  - Outputs stable while stalled.
  - Address sequence identical to the ready-high run; no beat lost or duplicated.
- Abort and reset: abort at beat 50.
  - Next cycle addr_valid=0, busy=0, no done pulse.
  - Restart yields beat 1 = ifm_base.
  - Repeat with rst_n low mid-run: all outputs at reset values.
- Start handling: start held high for the whole layer plus the done cycle.
  - Only one layer starts until the first IDLE cycle; a second run then starts with freshly latched config.
